// File: rtl/enclave_cmd_seq.sv
// Command sequencer: an opcode beat loads N operand words, then folds them with ADD/XOR/RXOR.
// Optional build macro ENCLAVE_CMD_SEQ_CHECK_EN enables command validation and the sticky err flag.
module enclave_cmd_seq #(
    parameter int MAX_WORDS = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        input_ready,
    input  logic        config_en,
    input  logic [31:0] wishbone_data,
    output logic        output_ready,
    output logic [31:0] wishbone_output,
    output logic        busy,
    output logic        err
);

    localparam int AW = $clog2(MAX_WORDS);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, LOAD, EXEC, DONE} state_e;

    state_e          state_q, state_d;
    logic            ir_q;
    logic            pend_q, pend_cfg_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   n_q, n_d;
    logic [7:0]      op_q, op_d;
    logic [31:0]     acc_q, acc_d;
    logic [31:0]     out_q, out_d;
    logic            rdy_q, rdy_d;
    logic            err_q, err_d;
    logic            buf_we;
    logic [31:0]     buf_q [MAX_WORDS];

    logic            beat;
    logic [7:0]      op_in;
    logic [3:0]      n_in;
    logic [CW-1:0]   n_eff;
    logic            cmd_bad;
    logic            unused_data;

    assign beat  = input_ready & ~ir_q;
    assign op_in = wishbone_data[7:0];
    assign n_in  = wishbone_data[11:8];
    assign unused_data = &{1'b0, wishbone_data[31:12]};

`ifdef ENCLAVE_CMD_SEQ_CHECK_EN
    assign cmd_bad = (n_in == 4'd0) || (int'(n_in) > MAX_WORDS)
                     || !(op_in inside {8'h01, 8'h02, 8'h03});
    assign n_eff   = CW'(n_in);
`else
    logic [CW-1:0] n_mod;
    // Out-of-range counts wrap modulo MAX_WORDS, with zero meaning a full buffer.
    assign n_mod   = CW'(n_in) & CW'(MAX_WORDS - 1);
    assign n_eff   = (n_mod == '0) ? CW'(MAX_WORDS) : n_mod;
    assign cmd_bad = 1'b0;
`endif

    function automatic logic [31:0] alu(input logic [7:0] op, input logic [31:0] a,
                                        input logic [31:0] w);
        case (op)
            8'h01:   return a + w;
            8'h03:   return {a[30:0], a[31]} ^ w;
            default: return a ^ w;
        endcase
    endfunction

    // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        op_d    = op_q;
        acc_d   = acc_q;
        out_d   = out_q;
        rdy_d   = 1'b0;
        err_d   = err_q;
        buf_we  = 1'b0;
        case (state_q)
            IDLE, LOAD: begin
                if (pend_q) begin
                    if (pend_cfg_q) begin
                        cnt_d = '0;
                        if (cmd_bad) begin
                            err_d   = 1'b1;
                            rdy_d   = 1'b1;
                            out_d   = 32'hDEAD_0000 | {20'h0, wishbone_data[11:0]};
                            state_d = IDLE;
                        end else begin
                            n_d     = n_eff;
                            op_d    = op_in;
                            state_d = LOAD;
                        end
                    end else if (state_q == LOAD) begin
                        buf_we = 1'b1;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == n_q) begin
                            cnt_d   = '0;
                            acc_d   = '0;
                            state_d = EXEC;
                        end
                    end
                end
            end
            EXEC: begin
                acc_d = alu(op_q, acc_q, buf_q[cnt_q[AW-1:0]]);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == n_q - 1'b1) begin
                    cnt_d   = '0;
                    out_d   = acc_d;
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= IDLE;
            ir_q       <= 1'b0;
            pend_q     <= 1'b0;
            pend_cfg_q <= 1'b0;
            cnt_q      <= '0;
            n_q        <= '0;
            op_q       <= '0;
            acc_q      <= '0;
            out_q      <= '0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= input_ready;
            // Beats arriving in EXEC or DONE are dropped here rather than queued.
            pend_q     <= beat & ((state_q == IDLE) || (state_q == LOAD));
            pend_cfg_q <= config_en;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            rdy_q      <= rdy_d;
            err_q      <= err_d;
        end
    end

    // NOTE: the operand buffer has no reset; it is always written before it is read.
    always_ff @(posedge wb_clk_i) begin
        if (buf_we) begin
            buf_q[cnt_q[AW-1:0]] <= wishbone_data;
        end
    end

    assign output_ready    = rdy_q;
    assign wishbone_output = out_q;
    assign busy            = (state_q != IDLE);
    assign err             = err_q;

endmodule

// File: tb/tb_enclave_cmd_seq.sv
// Directed self-checking bench for enclave_cmd_seq (MAX_WORDS=8); honours ENCLAVE_CMD_SEQ_CHECK_EN.
module tb_enclave_cmd_seq;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        input_ready;
    logic        config_en;
    logic [31:0] wishbone_data;
    logic        output_ready;
    logic [31:0] wishbone_output;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    enclave_cmd_seq #(.MAX_WORDS(8)) dut (
        .wb_clk_i        (wb_clk_i),
        .wb_rst_i        (wb_rst_i),
        .input_ready     (input_ready),
        .config_en       (config_en),
        .wishbone_data   (wishbone_data),
        .output_ready    (output_ready),
        .wishbone_output (wishbone_output),
        .busy            (busy),
        .err             (err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Beat cycle carries inverted data and config; the real data follows one cycle later.
    task automatic beat(input logic cfg, input logic [31:0] data, input int hold);
        @(posedge wb_clk_i); #1;
        input_ready   = 1'b1;
        config_en     = cfg;
        wishbone_data = ~data;
        @(posedge wb_clk_i); #1;
        input_ready   = (hold > 1);
        config_en     = ~cfg;
        wishbone_data = data;
        @(posedge wb_clk_i); #1;
        input_ready   = 1'b0;
        config_en     = 1'b0;
        wishbone_data = 32'h0;
    endtask

    // k=1 is the cycle right after the data-sample cycle of the last beat.
    task automatic watch(input int cycles, output int npulse, output int first_k,
                         output logic [31:0] val);
        npulse  = 0;
        first_k = 0;
        val     = 32'h0;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge wb_clk_i);
            if (output_ready === 1'b1) begin
                if (npulse == 0) begin
                    first_k = k;
                    val     = wishbone_output;
                end
                npulse++;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          np;
        int          fk;
        logic [31:0] v;

        wb_rst_i      = 1'b1;
        input_ready   = 1'b0;
        config_en     = 1'b0;
        wishbone_data = 32'h0;
        repeat (2) @(posedge wb_clk_i);
        #1;
        check("rst_output_ready", {31'h0, output_ready}, 32'h0);
        check("rst_wishbone_output", wishbone_output, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        wb_rst_i = 1'b0;

        // Data beat in IDLE is ignored.
        beat(1'b0, 32'h77, 1);
        check("idle_data_busy", {31'h0, busy}, 32'h0);
        watch(3, np, fk, v);
        check("idle_data_no_pulse", 32'(np), 32'd0);

        // ADD of 1, 2, 0xFFFFFFFF wraps to 2; DONE 4 cycles after last sample.
        beat(1'b1, 32'h0000_0301, 1);
        check("add_busy_load", {31'h0, busy}, 32'h1);
        beat(1'b0, 32'h1, 1);
        beat(1'b0, 32'h2, 1);
        beat(1'b0, 32'hFFFF_FFFF, 1);
        watch(8, np, fk, v);
        check("add_pulses", 32'(np), 32'd1);
        check("add_latency", 32'(fk), 32'd4);
        check("add_value", v, 32'h0000_0002);
        check("add_hold_value", wishbone_output, 32'h0000_0002);
        check("add_ready_low", {31'h0, output_ready}, 32'h0);
        check("add_busy_idle", {31'h0, busy}, 32'h0);

        // XOR with input_ready held two cycles per beat.
        beat(1'b1, 32'h0000_0202, 2);
        beat(1'b0, 32'hA5A5_A5A5, 2);
        beat(1'b0, 32'h0F0F_0F0F, 2);
        watch(6, np, fk, v);
        check("xor_pulses", 32'(np), 32'd1);
        check("xor_latency", 32'(fk), 32'd3);
        check("xor_value", v, 32'hAAAA_AAAA);

        // Rotate-XOR.
        beat(1'b1, 32'h0000_0203, 1);
        beat(1'b0, 32'h8000_0000, 1);
        beat(1'b0, 32'h0000_0001, 1);
        watch(6, np, fk, v);
        check("rxor_pulses", 32'(np), 32'd1);
        check("rxor_value", v, 32'h0000_0000);

        // Opcode beat in LOAD aborts and restarts.
        beat(1'b1, 32'h0000_0401, 1);
        beat(1'b0, 32'h1111_1111, 1);
        beat(1'b1, 32'h0000_0102, 1);
        beat(1'b0, 32'h1234_5678, 1);
        watch(10, np, fk, v);
        check("abort_pulses", 32'(np), 32'd1);
        check("abort_latency", 32'(fk), 32'd2);
        check("abort_value", v, 32'h1234_5678);

        // Opcode beat during EXEC is dropped.
        beat(1'b1, 32'h0000_0301, 1);
        beat(1'b0, 32'h1, 1);
        beat(1'b0, 32'h2, 1);
        beat(1'b0, 32'h3, 1);
        beat(1'b1, 32'h0000_0102, 1);
        watch(8, np, fk, v);
        check("exec_beat_pulses", 32'(np), 32'd1);
        check("exec_beat_value", v, 32'h0000_0006);
        beat(1'b0, 32'h55, 1);
        watch(6, np, fk, v);
        check("exec_beat_not_queued", 32'(np), 32'd0);

`ifdef ENCLAVE_CMD_SEQ_CHECK_EN
        beat(1'b1, 32'h0000_0009, 1);
        watch(4, np, fk, v);
        check("bad_op_pulses", 32'(np), 32'd1);
        check("bad_op_latency", 32'(fk), 32'd1);
        check("bad_op_value", v, 32'hDEAD_0009);
        check("bad_op_err", {31'h0, err}, 32'h1);
        check("bad_op_busy", {31'h0, busy}, 32'h0);
        beat(1'b1, 32'h0000_0A01, 1);
        watch(4, np, fk, v);
        check("bad_n_value", v, 32'hDEAD_0A01);
        beat(1'b1, 32'h0000_0102, 1);
        beat(1'b0, 32'h0000_0005, 1);
        watch(4, np, fk, v);
        check("after_err_value", v, 32'h0000_0005);
        check("err_sticky", {31'h0, err}, 32'h1);
`else
        // op 0x09 with N=0: eight words folded as XOR.
        beat(1'b1, 32'h0000_0009, 1);
        beat(1'b0, 32'h5, 1);
        beat(1'b0, 32'h5, 1);
        beat(1'b0, 32'h5, 1);
        beat(1'b0, 32'h3, 1);
        beat(1'b0, 32'h11, 1);
        beat(1'b0, 32'h0, 1);
        beat(1'b0, 32'h0, 1);
        beat(1'b0, 32'h0, 1);
        watch(12, np, fk, v);
        check("unk_op_pulses", 32'(np), 32'd1);
        check("unk_op_latency", 32'(fk), 32'd9);
        check("unk_op_value", v, 32'h0000_0017);
        // N=10 wraps to 2.
        beat(1'b1, 32'h0000_0A01, 1);
        beat(1'b0, 32'h3, 1);
        beat(1'b0, 32'h4, 1);
        watch(6, np, fk, v);
        check("wrap_n_latency", 32'(fk), 32'd3);
        check("wrap_n_value", v, 32'h0000_0007);
        check("no_err", {31'h0, err}, 32'h0);
`endif

        // Reset during EXEC abandons the command.
        beat(1'b1, 32'h0000_0801, 1);
        for (int i = 1; i <= 8; i++) begin
            beat(1'b0, 32'(i), 1);
        end
        @(posedge wb_clk_i); #1;
        check("exec_busy", {31'h0, busy}, 32'h1);
        wb_rst_i = 1'b1;
        #1;
        check("midrst_output_ready", {31'h0, output_ready}, 32'h0);
        check("midrst_wishbone_output", wishbone_output, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_err", {31'h0, err}, 32'h0);
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        watch(12, np, fk, v);
        check("midrst_no_pulse", 32'(np), 32'd0);

        // input_ready already high at reset release counts as a beat.
        @(posedge wb_clk_i); #1;
        wb_rst_i    = 1'b1;
        input_ready = 1'b1;
        config_en   = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i); #1;
        wishbone_data = 32'h0000_0101;
        config_en     = 1'b0;
        @(posedge wb_clk_i); #1;
        input_ready   = 1'b0;
        wishbone_data = 32'h0;
        check("rel_beat_busy", {31'h0, busy}, 32'h1);
        beat(1'b0, 32'h7, 1);
        watch(4, np, fk, v);
        check("rel_beat_pulses", 32'(np), 32'd1);
        check("rel_beat_value", v, 32'h0000_0007);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
